uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_cnt.sv | 29 ++
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default clock/baud rates and receiver FSM state encoding.
`timescale 1ns/1ps
package uart_pkg;

    localparam int CLK_HZ_DEF  = 50_000_000;
    localparam int BAUD_HZ_DEF = 115_200;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE      = 3'd0;
    localparam uart_state_t ST_START     = 3'd1;
    localparam uart_state_t ST_DATA      = 3'd2;
    localparam uart_state_t ST_STOP      = 3'd3;
    localparam uart_state_t ST_WAIT_IDLE = 3'd4;

endpackage

// File: rtl/uart_baud_cnt.sv
// Down-counter that reloads on demand and reports a tick while it rests at zero.
`timescale 1ns/1ps
module uart_baud_cnt #(
    parameter int W = 9
) (
    input  logic         clk_50,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tick
);

    logic [W-1:0] r_cnt;

    // NOTE: reset is sampled on the clock edge only, so it sits inside the
    // clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a single holding register, valid/ready handshake,
// frame-error and overrun pulses.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ  = CLK_HZ_DEF,
    parameter int BAUD_HZ = BAUD_HZ_DEF
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD_HZ;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    // A load of N makes the tick fire N+1 cycles after the load edge.
    localparam logic [CNT_W-1:0] LOAD_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] LOAD_FULL = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_sync1;
    logic             r_sync2;
    uart_state_t      r_state;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_ferr;
    logic             r_ovr;

    logic             w_rx_s;
    logic             w_tick;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_stop_good;
    logic             w_stop_bad;

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // NOTE: both outputs get a default before the case so no path leaves
    // them unassigned, which would otherwise infer a latch.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = LOAD_FULL;
        case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) begin
                    w_load     = 1'b1;
                    w_load_val = LOAD_HALF;
                end
            end
            ST_START: w_load = w_tick && !w_rx_s;
            ST_DATA:  w_load = w_tick;
            default:  w_load = 1'b0;
        endcase
    end

    uart_baud_cnt #(
        .W (CNT_W)
    ) u_baud_cnt (
        .clk_50     (clk_50),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tick     (w_tick)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_state   <= ST_START;
                        r_bit_cnt <= 3'd0;
                    end
                end
                ST_START: begin
                    if (w_tick) r_state <= w_rx_s ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_tick) r_state <= w_rx_s ? ST_IDLE : ST_WAIT_IDLE;
                end
                ST_WAIT_IDLE: begin
                    if (w_rx_s) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_stop_good = (r_state == ST_STOP) && w_tick && w_rx_s;
    assign w_stop_bad  = (r_state == ST_STOP) && w_tick && !w_rx_s;

    // A new byte may load in the same cycle the old one is consumed.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_stop_bad;
            r_ovr  <= w_stop_good && r_valid && !rx_ready;
            if (w_stop_good && (!r_valid || rx_ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, directed corner cases and
// randomized frames against a holding-register reference model.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB     = 50_000_000 / 115_200;
    localparam int HALF    = CPB / 2;
    localparam int NOM_LAT = 2 + HALF + 9 * CPB + 1;

    logic       clk_50   = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx       = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    always #10 clk_50 = ~clk_50;

    uart_rx dut (
        .clk_50    (clk_50),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int start_cyc = 0;

    always @(posedge clk_50) cyc <= cyc + 1;

    // Monitor, sampled on the falling edge while everything is stable.
    logic [7:0] got_q[$];
    int   ferr_cnt = 0, ovr_cnt = 0, rise_cnt = 0, rise_cyc = 0;
    int   run_len = 0, last_len = 0, both_cnt = 0, long_cnt = 0;
    logic prev_valid = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;

    always @(negedge clk_50) begin
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (overrun) ovr_cnt <= ovr_cnt + 1;
        if (frame_err && overrun) both_cnt <= both_cnt + 1;
        if ((frame_err && prev_ferr) || (overrun && prev_ovr)) long_cnt <= long_cnt + 1;
        if (rx_valid && !prev_valid) begin
            rise_cnt <= rise_cnt + 1;
            rise_cyc <= cyc;
        end
        if (rx_valid) begin
            run_len <= run_len + 1;
        end else begin
            if (run_len > 0) last_len <= run_len;
            run_len <= 0;
        end
        prev_valid <= rx_valid;
        prev_ferr  <= frame_err;
        prev_ovr   <= overrun;
    end

    typedef struct {
        logic [7:0] data;
        int         stop_low;
        bit         ready;
        int         exp_acc;
        logic [7:0] exp_acc_data;
        int         exp_ferr;
        int         exp_ovr;
        int         exp_rise;
        bit         exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[5];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_50);
            #2;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        n_checks++;
        if (got < lo || got > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int stop_low);
        rx = 1'b0;
        start_cyc = cyc;
        tick(CPB);
        for (int b = 0; b < 8; b++) begin
            rx = d[b];
            tick(CPB);
        end
        if (stop_low > 0) begin
            rx = 1'b0;
            tick(stop_low);
        end
        rx = 1'b1;
        tick(CPB);
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        int n0, f0, o0, r0;
        n0 = got_q.size();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        r0 = rise_cnt;
        rx_ready = v.ready;
        send_frame(v.data, v.stop_low);
        tick(20);
        check({tag, "_acc_n"}, got_q.size() - n0, v.exp_acc);
        if (v.exp_acc > 0 && got_q.size() > n0)
            check({tag, "_acc_data"}, got_q[n0], v.exp_acc_data);
        check({tag, "_frame_err"}, ferr_cnt - f0, v.exp_ferr);
        check({tag, "_overrun"}, ovr_cnt - o0, v.exp_ovr);
        check({tag, "_valid_rise"}, rise_cnt - r0, v.exp_rise);
        if (v.exp_rise > 0 && rise_cnt > r0)
            check_range({tag, "_latency"}, rise_cyc - start_cyc, NOM_LAT - 1, NOM_LAT + 1);
        if (v.exp_rise > 0 && v.ready)
            check({tag, "_valid_len"}, last_len, 1);
        check({tag, "_rx_valid"}, rx_valid, v.exp_valid);
        check({tag, "_rx_data"}, rx_data, v.exp_data);
    endtask

    initial begin : main
        bit         m_valid;
        logic [7:0] m_data;
        int         n0, r0, f0;
        vec_t       v;

        tbl[0] = '{8'hA5, 0,       1'b1, 1, 8'hA5, 0, 0, 1, 1'b0, 8'hA5};
        tbl[1] = '{8'h3C, 2 * CPB, 1'b1, 0, 8'h00, 1, 0, 0, 1'b0, 8'hA5};
        tbl[2] = '{8'h81, 0,       1'b1, 1, 8'h81, 0, 0, 1, 1'b0, 8'h81};
        tbl[3] = '{8'h11, 0,       1'b0, 0, 8'h00, 0, 0, 1, 1'b1, 8'h11};
        tbl[4] = '{8'h22, 0,       1'b0, 0, 8'h00, 0, 1, 0, 1'b1, 8'h11};

        // Reset state
        rst_n = 1'b0;
        tick(5);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick(5);

        for (int i = 0; i < 5; i++) apply_vec($sformatf("vec%0d", i), tbl[i]);

        // Consuming the held byte clears rx_valid on the following cycle
        n0 = got_q.size();
        rx_ready = 1'b1;
        tick(1);
        check("consume_valid_clear", rx_valid, 1'b0);
        check("consume_n", got_q.size() - n0, 1);
        if (got_q.size() > n0) check("consume_data", got_q[n0], 8'h11);
        check("consume_data_kept", rx_data, 8'h11);

        // Reset during the bit-4 sample of 0xF0
        tick(2);
        r0 = rise_cnt;
        rx = 1'b0;
        tick(5 * CPB);
        rx = 1'b1;
        tick(HALF);
        check("midrst_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("midrst_rx_valid", rx_valid, 1'b0);
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_frame_err", frame_err, 1'b0);
        check("midrst_overrun", overrun, 1'b0);
        check("midrst_busy", busy, 1'b0);
        tick(4 * CPB + 20);
        check("midrst_no_output", rise_cnt - r0, 0);
        v = '{8'h5A, 0, 1'b1, 1, 8'h5A, 0, 0, 1, 1'b0, 8'h5A};
        apply_vec("after_rst", v);

        // Short low glitch is rejected at the start-bit midpoint
        r0 = rise_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        tick(50);
        check("glitch_busy_high", busy, 1'b1);
        tick(50);
        rx = 1'b1;
        tick(HALF + 3);
        check("glitch_busy_low", busy, 1'b0);
        check("glitch_no_valid", rise_cnt - r0, 0);
        check("glitch_no_ferr", ferr_cnt - f0, 0);

        // Back-to-back frames with no idle gap
        rx_ready = 1'b1;
        n0 = got_q.size();
        r0 = rise_cnt;
        send_frame(8'h00, 0);
        send_frame(8'hFF, 0);
        send_frame(8'h55, 0);
        tick(20);
        check("b2b_n", got_q.size() - n0, 3);
        check("b2b_rise", rise_cnt - r0, 3);
        if (got_q.size() >= n0 + 3) begin
            check("b2b_d0", got_q[n0], 8'h00);
            check("b2b_d1", got_q[n0+1], 8'hFF);
            check("b2b_d2", got_q[n0+2], 8'h55);
        end

        // Randomized frames against the holding-register model
        m_valid = 1'b0;
        m_data  = 8'h55;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            bit good, r;
            d    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            r    = 1'($urandom_range(0, 1));
            n0 = got_q.size();
            rx_ready = r;
            tick(2);
            if (r && m_valid) begin
                check($sformatf("rnd%0d_flush_n", i), got_q.size() - n0, 1);
                if (got_q.size() > n0) check($sformatf("rnd%0d_flush_data", i), got_q[n0], m_data);
                m_valid = 1'b0;
            end
            v = '{d, good ? 0 : CPB, r, 0, 8'h00, 0, 0, 0, 1'b0, 8'h00};
            if (!good) begin
                v.exp_ferr = 1;
            end else if (m_valid && !r) begin
                v.exp_ovr = 1;
            end else begin
                v.exp_rise = 1;
                m_data = d;
                if (r) begin
                    v.exp_acc      = 1;
                    v.exp_acc_data = d;
                end else begin
                    m_valid = 1'b1;
                end
            end
            v.exp_valid = m_valid;
            v.exp_data  = m_data;
            apply_vec($sformatf("rnd%0d", i), v);
        end

        check("err_ovr_coincident", both_cnt, 0);
        check("pulse_width", long_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
